// File: rtl/conv_pkg.sv
// Constants shared by the conv adder stages and the accumulate/requantize stage.
package conv_pkg;
  localparam int PSUM_W = 18;
  localparam int PIX_W  = 16;
  localparam int BIAS_W = 16;
  localparam logic signed [PIX_W-1:0] PIX_MAX = {1'b0, {(PIX_W-1){1'b1}}};
  localparam logic signed [PIX_W-1:0] PIX_MIN = {1'b1, {(PIX_W-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_ACCUM} acc_state_e;

  // Narrowest accumulator that cannot overflow for n full-scale terms plus bias.
  function automatic int min_acc_w(input int n);
    return 19 + $clog2(n);
  endfunction
endpackage

// File: rtl/requant_sat.sv
// Requantize an accumulator: arithmetic shift (floor), optional ReLU, clamp to pixel range.
module requant_sat
  import conv_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    relu_en,
  output logic signed [PIX_W-1:0] pix,
  output logic                    sat
);
  localparam logic signed [ACC_W-1:0] MAX_X = {{(ACC_W-PIX_W){PIX_MAX[PIX_W-1]}}, PIX_MAX};
  localparam logic signed [ACC_W-1:0] MIN_X = {{(ACC_W-PIX_W){PIX_MIN[PIX_W-1]}}, PIX_MIN};

  logic signed [ACC_W-1:0] shifted, clamped;

  always_comb begin
    shifted = acc >>> SHIFT;
    clamped = (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
    pix     = clamped[PIX_W-1:0];
    sat     = 1'b0;
    if (clamped > MAX_X) begin
      pix = PIX_MAX;
      sat = 1'b1;
    end else if (clamped < MIN_X) begin
      pix = PIX_MIN;
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/conv_accum_requant.sv
// Accumulates NUM_TERMS stage-2 partial sums plus bias per pixel, then requantizes
// into a single-entry output register with valid/ready backpressure.
module conv_accum_requant
  import conv_pkg::*;
#(
  parameter int NUM_TERMS = 3,
  parameter int SHIFT     = 4,
  parameter int ACC_W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PSUM_W-1:0] in_sum,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PIX_W-1:0]  out_data,
  output logic                     out_sat
);
  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  if (NUM_TERMS < 1 || NUM_TERMS > 64) begin : g_bad_terms
    $error("NUM_TERMS out of range 1..64");
  end
  if (SHIFT < 0 || SHIFT > 15) begin : g_bad_shift
    $error("SHIFT out of range 0..15");
  end
  if (ACC_W < min_acc_w(NUM_TERMS)) begin : g_bad_acc
    $error("ACC_W too narrow for NUM_TERMS");
  end

  acc_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [PIX_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    accept, first, last;
  logic signed [ACC_W-1:0] acc_base, acc_next;
  logic signed [PIX_W-1:0] rq_pix;
  logic                    rq_sat;

  assign last     = (cnt_q == LAST);
  // Only the closing term is held back by a stalled output; earlier terms keep flowing.
  assign in_ready = enable && !(last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable)     state_d = ST_IDLE;
    else if (accept) state_d = last ? ST_IDLE : ST_ACCUM;
  end

  always_comb begin
    first = (state_q == ST_IDLE);
  end

  always_comb begin
    acc_base = first ? {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} : acc_q;
    acc_next = acc_base + {{(ACC_W-PSUM_W){in_sum[PSUM_W-1]}}, in_sum};
  end

  requant_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_requant_sat (
    .acc     (acc_next),
    .relu_en (relu_en),
    .pix     (rq_pix),
    .sat     (rq_sat)
  );

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (!enable) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      acc_d = last ? '0 : acc_next;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (accept && last) begin
      out_valid_d = 1'b1;
      out_data_d  = rq_pix;
      out_sat_d   = rq_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_conv_accum_requant.sv
// Bench for conv_accum_requant: directed scenarios plus random traffic, two instances
// (SHIFT=4 and SHIFT=2) fed identically and checked against a group-level model.
module tb_conv_accum_requant;
  localparam int NT = 3;

  logic        clk = 1'b0;
  logic        rst_n, enable, in_valid, relu_en, out_ready;
  logic [17:0] in_sum;
  logic [15:0] bias;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_data;
  logic        in_ready2, out_valid2, out_sat2;
  logic [15:0] out_data2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] d4;
    logic        s4;
    logic [15:0] d2;
    logic        s2;
  } exp_t;

  exp_t   expq[$];
  longint grp[$];
  longint gbias;

  always #5 clk = ~clk;

  conv_accum_requant #(.NUM_TERMS(NT), .SHIFT(4), .ACC_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .bias(bias), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat));

  conv_accum_requant #(.NUM_TERMS(NT), .SHIFT(2), .ACC_W(24)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready2),
    .in_sum(in_sum), .bias(bias), .relu_en(relu_en), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Floor division by 2^sh, then ReLU, then clamp to 16-bit signed.
  function automatic void requant(input longint acc, input int sh, input bit relu,
                                  output logic [15:0] d, output logic s);
    longint dv, r;
    dv = longint'(1) << sh;
    r  = (acc >= 0) ? acc / dv : -((-acc + dv - 1) / dv);
    if (relu && r < 0) r = 0;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
    d = r[15:0];
  endfunction

  // Model advances on negedges, when the inputs for the coming edge are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      grp.delete();
      expq.delete();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    end else begin
      chk("in_ready", {31'b0, in_ready},
          {31'b0, enable && !(grp.size() == NT-1 && expq.size() > 0 && !out_ready)});
      chk("in_ready_s2", {31'b0, in_ready2}, {31'b0, in_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, expq.size() > 0});
      chk("out_valid_s2", {31'b0, out_valid2}, {31'b0, expq.size() > 0});
      if (expq.size() > 0) begin
        chk("out_data", {16'b0, out_data}, {16'b0, expq[0].d4});
        chk("out_sat", {31'b0, out_sat}, {31'b0, expq[0].s4});
        chk("out_data_s2", {16'b0, out_data2}, {16'b0, expq[0].d2});
        chk("out_sat_s2", {31'b0, out_sat2}, {31'b0, expq[0].s2});
        if (out_ready) void'(expq.pop_front());
      end
      if (!enable) grp.delete();
      else if (in_valid && in_ready) begin
        if (grp.size() == 0) gbias = longint'($signed(bias));
        grp.push_back(longint'($signed(in_sum)));
        if (grp.size() == NT) begin
          longint tot;
          exp_t e;
          tot = gbias;
          foreach (grp[i]) tot += grp[i];
          requant(tot, 4, relu_en, e.d4, e.s4);
          requant(tot, 2, relu_en, e.d2, e.s2);
          expq.push_back(e);
          grp.delete();
        end
      end
    end
  end

  task automatic send(input int s, input int b, input bit relu);
    bit ok = 1'b0;
    in_sum = 18'(s); bias = 16'(b); relu_en = relu; in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("send_accepted", {31'b0, ok}, 32'd1);
  endtask

  // Bias only matters on the first beat, relu only on the last; junk elsewhere.
  task automatic group(input int b, input int s0, input int s1, input int s2, input bit relu);
    send(s0, b, $urandom_range(0, 1));
    send(s1, int'($urandom), $urandom_range(0, 1));
    send(s2, int'($urandom), relu);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    in_sum = '0; bias = '0;
    @(negedge clk);
    chk("reset_data", {16'b0, out_data}, 32'd0);
    chk("reset_sat", {31'b0, out_sat}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1;

    // Basic
    group(16, 100, 200, -50, 1'b0);
    @(negedge clk);
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_data", {16'b0, out_data}, 32'd16);
    chk("basic_sat", {31'b0, out_sat}, 32'd0);
    @(posedge clk); #1;

    // ReLU
    group(0, -1000, -1000, -1000, 1'b1);
    @(negedge clk);
    chk("relu_on_data", {16'b0, out_data}, 32'd0);
    chk("relu_on_sat", {31'b0, out_sat}, 32'd0);
    @(posedge clk); #1;
    group(0, -1000, -1000, -1000, 1'b0);
    @(negedge clk);
    chk("relu_off_data", {16'b0, out_data}, 32'h0000ff44);
    @(posedge clk); #1;

    // Saturation on the SHIFT=2 instance
    group(0, 131071, 131071, 131071, 1'b0);
    @(negedge clk);
    chk("sat_pos_data", {16'b0, out_data2}, 32'h00007fff);
    chk("sat_pos_sat", {31'b0, out_sat2}, 32'd1);
    @(posedge clk); #1;
    group(0, -131072, -131072, -131072, 1'b0);
    @(negedge clk);
    chk("sat_neg_data", {16'b0, out_data2}, 32'h00008000);
    chk("sat_neg_sat", {31'b0, out_sat2}, 32'd1);
    @(posedge clk); #1;

    // Backpressure: group 1 stalls, group 2 streams up to its last term
    out_ready = 1'b0;
    group(0, 16, 16, 16, 1'b0);
    send(160, 0, 1'b0);
    send(320, 0, 1'b0);
    in_sum = 18'd480; relu_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_held", {31'b0, in_ready}, 32'd0);
    chk("bp_data", {16'b0, out_data}, 32'd3);
    @(posedge clk); @(negedge clk);
    chk("bp_held2", {31'b0, in_ready}, 32'd0);
    chk("bp_stable", {16'b0, out_data}, 32'd3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_swap_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_swap_data", {16'b0, out_data}, 32'd60);
    @(posedge clk); #1;

    // Abort
    send(5000, 0, 1'b0);
    send(5000, 0, 1'b0);
    enable = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    enable = 1'b1; in_valid = 1'b0;
    group(0, 1, 2, 3, 1'b0);
    @(negedge clk);
    chk("abort_data", {16'b0, out_data}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-group
    send(7000, 500, 1'b0);
    send(7000, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_grp_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-stall
    out_ready = 1'b0;
    group(0, 1600, 1600, 1600, 1'b0);
    send(900, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_stall_data", {16'b0, out_data}, 32'd0);
    chk("rst_stall_sat", {31'b0, out_sat}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    group(16, 100, 200, -50, 1'b0);
    @(negedge clk);
    chk("post_rst_data", {16'b0, out_data}, 32'd16);
    @(posedge clk); #1;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      enable    = ($urandom % 16) != 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      relu_en   = $urandom_range(0, 1);
      bias      = 16'($urandom);
      case ($urandom % 4)
        0:       in_sum = 18'h1ffff;
        1:       in_sum = 18'h20000;
        default: in_sum = 18'($urandom);
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_accum_requant.md
CONV_ACCUM_REQUANT -- requirements
Module: conv_accum_requant

Interface
REQ-001 Parameter NUM_TERMS, default 3: number of stage-2 partial sums accumulated into one output pixel; legal range 1..64.
REQ-002 Parameter SHIFT, default 4: arithmetic right-shift applied before saturation; legal range 0..15.
REQ-003 Parameter ACC_W, default 24: accumulator width; SHALL be at least 19+ceil(log2(NUM_TERMS)), which is checked at elaboration.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  block enable; low aborts the partial group.
REQ-007 in_valid  in  1  in_sum is valid this cycle.
REQ-008 in_ready  out  1  the block accepts in_sum this cycle.
REQ-009 in_sum  in  18  signed two's-complement partial sum from the stage-2 adder.
REQ-010 bias  in  16  signed bias, sampled with the first term of each group.
REQ-011 relu_en  in  1  clamp negative results to 0, sampled with the last term.
REQ-012 out_valid  out  1  out_data holds a result.
REQ-013 out_ready  in  1  the downstream stage takes out_data.
REQ-014 out_data  out  16  signed requantized pixel.
REQ-015 out_sat  out  1  out_data was clamped by saturation; qualified by out_valid.

Function
REQ-016 Transfer: an input beat is accepted when in_valid && in_ready; an output beat is accepted when out_valid && out_ready.
REQ-017 Term counter cnt runs 0..NUM_TERMS-1. It increments on each accepted beat and wraps to 0 after the last term.
REQ-018 States:
- IDLE: cnt==0, accumulator empty.
- ACCUM: 0<cnt<NUM_TERMS.
- Transition IDLE->ACCUM on the first beat.
- Transition ACCUM->IDLE on the last beat.
- With NUM_TERMS==1, every accepted beat is both first and last.
REQ-019 First beat: acc <= sext(bias) + sext(in_sum), both sign-extended to ACC_W. Later beats: acc <= acc + sext(in_sum).
REQ-020 Last beat, combinational path:
- r = (acc_next >>> SHIFT), arithmetic shift, floor rounding.
- If relu_en and r<0, then r=0.
- Saturate to [-32768, 32767].
- The result registers into out_data on the same edge.
- out_sat = 1 only if the saturation step changed the value.
REQ-021 Latency: out_valid rises on the clock edge that accepts the last term, so the result is visible in the following cycle.
REQ-022 in_ready = enable && !(cnt==NUM_TERMS-1 && out_valid && !out_ready). Non-last terms keep accumulating while the output is stalled; only the last term is held back.
REQ-023 Output register behaviour:
- Holds out_data and out_sat stable while out_valid && !out_ready.
- Clears out_valid after acceptance unless a new last term is accepted on the same edge.
- A simultaneous drain and new result loads the new result and keeps out_valid=1.
REQ-024 enable low:
- in_ready=0.
- cnt and acc clear to 0 on the next edge, abandoning the partial group.
- A pending output is unaffected and still drains normally.
REQ-025 A beat presented with in_valid while in_ready==0 is not consumed and leaves no state change.

Reset
REQ-026 While rst_n==0, these SHALL be 0 immediately (asynchronous): out_valid, out_data, out_sat, cnt, acc.
REQ-027 Reset deassertion SHALL be synchronized externally. The first accepted beat after reset is treated as a first term.
REQ-028 Reset mid-group or mid-stall discards all partial and pending results with no output beat.

Structure
REQ-029 Package conv_pkg SHALL hold these constants, shared with the adder stages: PSUM_W=18, PIX_W=16, PIX_MAX, PIX_MIN.
REQ-030 Sub-module requant_sat SHALL hold the combinational shift, ReLU and saturate logic, parameterized by ACC_W and SHIFT. No other sub-modules.

Verification
REQ-031 The bench SHALL cover these directed scenarios with NUM_TERMS=3 and SHIFT=4 unless a scenario states otherwise:
- Basic: bias=16; sums 100, 200, -50 on back-to-back cycles -> one cycle after the third beat, out_valid=1, out_data=16, out_sat=0.
- ReLU: bias=0; sums -1000 x3:
  - relu_en=1 -> out_data=0, out_sat=0.
  - relu_en=0 -> out_data=-188 (0xFF44).
- Saturation (SHIFT=2): bias=0; sums 131071 x3 -> out_data=32767, out_sat=1. With sums -131072 x3 -> out_data=-32768, out_sat=1.
- Backpressure: out_ready=0 after group 1, group 2 streamed continuously:
  - Terms 1-2 of group 2 are accepted.
  - in_ready=0 on term 3 and out_data stays stable.
  - out_ready=1 -> group-1 drain and group-2 last-term acceptance occur on the same edge, and out_valid stays 1.
- Abort: enable=0 after 2 terms, then a full new group 1, 2, 3 with bias=0 -> out_data=0 (6>>>4), with no contribution from the aborted terms.
- Reset: assert rst_n=0 mid-group and mid-stall -> all outputs are 0 asynchronously. After release, the next group's result is correct.
